// File: rtl/npu_mac_sequencer.sv
// Pass sequencer for the NPU 3x3 MAC array: waits for operands, clears the PE
// accumulators, then walks the weight/input mux selects through every tap.
module npu_mac_sequencer #(
  parameter int N               = 10,
  parameter int K_SIZE          = 3,
  parameter int SEL_MUX_A_WIDTH = 4,
  parameter int SEL_MUX_B_WIDTH = 5,
  parameter int PASS_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [N-1:0]               pe_mask_i,
  input  logic [PASS_W-1:0]          num_pass_i,
  input  logic                       abort_i,
  input  logic                       buf_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [PASS_W-1:0]          pass_cnt_o,
  output logic [N-1:0]               pe_en_o,
  output logic [N-1:0]               pe_mode_sel_o,
  output logic [N-1:0]               pe_reg_reset_o,
  output logic [SEL_MUX_A_WIDTH-1:0] mux_a_sel_o,
  output logic [SEL_MUX_B_WIDTH-1:0] mux_b_sel_o,
  output logic                       result_valid_o,
  output logic                       buf_release_o
);

  localparam int TAPS = K_SIZE * K_SIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                 state_q, state_d;
  logic [SEL_MUX_A_WIDTH-1:0] tap_q, tap_d;
  logic [PASS_W-1:0]          pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0]          num_pass_q, num_pass_d;
  logic [PASS_W-1:0]          pass_inc;
  logic                       mode_q, mode_d;
  logic [N-1:0]               mask_q, mask_d;

  logic                       busy_d, done_d, rv_d;
  logic [N-1:0]               pe_en_d, pe_mode_d, pe_rst_d;
  logic [SEL_MUX_A_WIDTH-1:0] mux_a_d;
  logic [SEL_MUX_B_WIDTH-1:0] mux_b_d;
  logic                       busy_q, done_q, rv_q;
  logic [N-1:0]               pe_en_q, pe_mode_q, pe_rst_q;
  logic [SEL_MUX_A_WIDTH-1:0] mux_a_q;
  logic [SEL_MUX_B_WIDTH-1:0] mux_b_q;

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    pass_cnt_d = pass_cnt_q;
    num_pass_d = num_pass_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    pass_inc   = pass_cnt_q + 1'b1;

    // Abort beats every transition, including the DRAIN count update.
    if (state_q != S_IDLE && abort_i) begin
      state_d = S_IDLE;
      tap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            pass_cnt_d = '0;
            if (num_pass_i != '0) begin
              mode_d     = mode_i;
              mask_d     = pe_mask_i;
              num_pass_d = num_pass_i;
              state_d    = S_WAIT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_WAIT:  if (buf_ready_i) state_d = S_CLEAR;
        S_CLEAR: begin
          tap_d   = '0;
          state_d = S_MAC;
        end
        S_MAC: begin
          if (tap_q == SEL_MUX_A_WIDTH'(TAPS - 1)) begin
            tap_d   = '0;
            state_d = S_DRAIN;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
        S_DRAIN: begin
          pass_cnt_d = pass_inc;
          state_d    = (pass_inc == num_pass_q) ? S_DONE : S_WAIT;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state so they line up with the state register.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    rv_d      = (state_d == S_DRAIN);
    pe_en_d   = (state_d == S_MAC)   ? mask_d : '0;
    pe_rst_d  = (state_d == S_CLEAR) ? mask_d : '0;
    pe_mode_d = (state_d != S_IDLE)  ? {N{mode_d}} : '0;
    mux_a_d   = '0;
    mux_b_d   = '0;
    if (state_d == S_MAC) begin
      mux_a_d = tap_d;
      mux_b_d = SEL_MUX_B_WIDTH'(tap_d) + (mode_d ? SEL_MUX_B_WIDTH'(TAPS) : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      pass_cnt_q <= '0;
      num_pass_q <= '0;
      mode_q     <= 1'b0;
      mask_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      pe_en_q    <= '0;
      pe_rst_q   <= '0;
      pe_mode_q  <= '0;
      mux_a_q    <= '0;
      mux_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      pass_cnt_q <= pass_cnt_d;
      num_pass_q <= num_pass_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rv_q       <= rv_d;
      pe_en_q    <= pe_en_d;
      pe_rst_q   <= pe_rst_d;
      pe_mode_q  <= pe_mode_d;
      mux_a_q    <= mux_a_d;
      mux_b_q    <= mux_b_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_cnt_o     = pass_cnt_q;
  assign pe_en_o        = pe_en_q;
  assign pe_mode_sel_o  = pe_mode_q;
  assign pe_reg_reset_o = pe_rst_q;
  assign mux_a_sel_o    = mux_a_q;
  assign mux_b_sel_o    = mux_b_q;
  assign result_valid_o = rv_q;
  assign buf_release_o  = rv_q;

endmodule

// File: tb/tb_npu_mac_sequencer.sv
// Bench for npu_mac_sequencer: directed timing checks plus random jobs checked
// every cycle against a pass-phase model.
module tb_npu_mac_sequencer;
  localparam int N  = 10;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, mode_i = 1'b0, abort_i = 1'b0, buf_ready_i = 1'b0;
  logic [N-1:0]  pe_mask_i = '0;
  logic [PW-1:0] num_pass_i = '0;
  logic          busy_o, done_o, result_valid_o, buf_release_o;
  logic [PW-1:0] pass_cnt_o;
  logic [N-1:0]  pe_en_o, pe_mode_sel_o, pe_reg_reset_o;
  logic [3:0]    mux_a_sel_o;
  logic [4:0]    mux_b_sel_o;

  int vectors = 0;
  int miscompares = 0;

  npu_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .pe_mask_i(pe_mask_i), .num_pass_i(num_pass_i), .abort_i(abort_i),
    .buf_ready_i(buf_ready_i), .busy_o(busy_o), .done_o(done_o),
    .pass_cnt_o(pass_cnt_o), .pe_en_o(pe_en_o), .pe_mode_sel_o(pe_mode_sel_o),
    .pe_reg_reset_o(pe_reg_reset_o), .mux_a_sel_o(mux_a_sel_o),
    .mux_b_sel_o(mux_b_sel_o), .result_valid_o(result_valid_o),
    .buf_release_o(buf_release_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ph = -1 idle, 0 waiting for buffer, 1 clear, 2..10 taps 0..8,
  // 11 drain, 12 done.
  int           ph = -1;
  int           m_np = 0, m_pcnt = 0;
  logic         m_mode = 1'b0;
  logic [N-1:0] m_mask = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= -1; m_np <= 0; m_pcnt <= 0; m_mode <= 1'b0; m_mask <= '0;
    end else if (ph == -1) begin
      if (start_i) begin
        m_pcnt <= 0;
        if (num_pass_i != 0) begin
          m_mode <= mode_i; m_mask <= pe_mask_i; m_np <= int'(num_pass_i); ph <= 0;
        end else ph <= 12;
      end
    end else if (abort_i) ph <= -1;
    else if (ph == 0) begin
      if (buf_ready_i) ph <= 1;
    end else if (ph <= 10) ph <= ph + 1;
    else if (ph == 11) begin
      m_pcnt <= m_pcnt + 1;
      ph <= (m_pcnt + 1 == m_np) ? 12 : 0;
    end else ph <= -1;
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy_o), 32'(ph != -1));
    chk("done", 32'(done_o), 32'(ph == 12));
    chk("pe_en", 32'(pe_en_o), (ph >= 2 && ph <= 10) ? 32'(m_mask) : 32'd0);
    chk("pe_reset", 32'(pe_reg_reset_o), (ph == 1) ? 32'(m_mask) : 32'd0);
    chk("mux_a", 32'(mux_a_sel_o), (ph >= 2 && ph <= 10) ? 32'(ph - 2) : 32'd0);
    chk("mux_b", 32'(mux_b_sel_o),
        (ph >= 2 && ph <= 10) ? 32'(ph - 2 + (m_mode ? 9 : 0)) : 32'd0);
    chk("result_valid", 32'(result_valid_o), 32'(ph == 11));
    chk("buf_release", 32'(buf_release_o), 32'(ph == 11));
    chk("mode_sel", 32'(pe_mode_sel_o), (ph != -1 && m_mode) ? 32'h3FF : 32'd0);
    chk("pass_cnt", 32'(pass_cnt_o), 32'(m_pcnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic job(input logic md, input logic [N-1:0] mk, input logic [PW-1:0] np);
    start_i = 1'b1; mode_i = md; pe_mask_i = mk; num_pass_i = np;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_pass_cnt", 32'(pass_cnt_o), 32'd0);

    // Single pass, mode 0, full mask.
    job(1'b0, 10'h3FF, 8'd1); buf_ready_i = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) start_i = 1'b0;
      chk("t1_busy", 32'(busy_o), 32'(c <= 13));
      chk("t1_reset", 32'(pe_reg_reset_o), (c == 2) ? 32'h3FF : 32'd0);
      chk("t1_en", 32'(pe_en_o), (c >= 3 && c <= 11) ? 32'h3FF : 32'd0);
      chk("t1_mux_a", 32'(mux_a_sel_o), (c >= 3 && c <= 11) ? 32'(c - 3) : 32'd0);
      chk("t1_mux_b", 32'(mux_b_sel_o), (c >= 3 && c <= 11) ? 32'(c - 3) : 32'd0);
      chk("t1_rv", 32'(result_valid_o), 32'(c == 12));
      chk("t1_done", 32'(done_o), 32'(c == 13));
    end
    chk("t1_pass_cnt", 32'(pass_cnt_o), 32'd1);

    // Two passes, broadcast mode, buffer late by 4 cycles before pass 2.
    tick();
    job(1'b1, 10'h005, 8'd2);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) start_i = 1'b0;
      if (c == 13) buf_ready_i = 1'b0;
      if (c == 17) buf_ready_i = 1'b1;
      if (c == 3)  chk("t2_mux_b_first", 32'(mux_b_sel_o), 32'd9);
      if (c == 11) chk("t2_mux_b_last", 32'(mux_b_sel_o), 32'd17);
      if (c == 3)  chk("t2_en", 32'(pe_en_o), 32'h005);
      if (c == 14) chk("t2_no_clear", 32'(pe_reg_reset_o), 32'd0);
      if (c == 18) chk("t2_clear2", 32'(pe_reg_reset_o), 32'h005);
      chk("t2_done", 32'(done_o), 32'(c == 29));
    end
    chk("t2_pass_cnt", 32'(pass_cnt_o), 32'd2);

    // Zero-pass job.
    job(1'b0, 10'h3FF, 8'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) start_i = 1'b0;
      chk("t3_done", 32'(done_o), 32'(c == 1));
      chk("t3_busy", 32'(busy_o), 32'(c == 1));
      chk("t3_en", 32'(pe_en_o | pe_reg_reset_o), 32'd0);
      chk("t3_release", 32'(buf_release_o), 32'd0);
    end
    chk("t3_pass_cnt", 32'(pass_cnt_o), 32'd0);

    // Abort at MAC tap 4, then a normal job.
    job(1'b0, 10'h3FF, 8'd3);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) start_i = 1'b0;
      if (c == 7) begin
        chk("t4_tap4", 32'(mux_a_sel_o), 32'd4);
        abort_i = 1'b1;
      end
    end
    abort_i = 1'b0;
    chk("t4_busy", 32'(busy_o), 32'd0);
    chk("t4_en", 32'(pe_en_o), 32'd0);
    chk("t4_done", 32'(done_o), 32'd0);
    chk("t4_pass_cnt", 32'(pass_cnt_o), 32'd0);
    job(1'b0, 10'h00F, 8'd1);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) start_i = 1'b0;
      chk("t4_restart_done", 32'(done_o), 32'(c == 13));
    end

    // Extra start while busy is ignored; reset mid-MAC clears outputs at once.
    tick();
    job(1'b0, 10'h3FF, 8'd2);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) start_i = 1'b0;
      if (c == 5) job(1'b1, 10'h001, 8'd7);
      if (c == 6) begin
        start_i = 1'b0;
        chk("t5_ignored_mode", 32'(pe_mode_sel_o), 32'd0);
        chk("t5_ignored_en", 32'(pe_en_o), 32'h3FF);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_en", 32'(pe_en_o), 32'd0);
    chk("t5_rst_mux", 32'(mux_a_sel_o), 32'd0);
    chk("t5_rst_cnt", 32'(pass_cnt_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n       = ($urandom_range(0, 499) != 0);
      start_i     = ($urandom_range(0, 7) == 0);
      abort_i     = ($urandom_range(0, 39) == 0);
      buf_ready_i = ($urandom_range(0, 9) < 7);
      mode_i      = 1'($urandom_range(0, 1));
      pe_mask_i   = N'($urandom_range(0, 1023));
      num_pass_i  = ($urandom_range(0, 15) == 0) ? PW'($urandom_range(0, 255))
                                                 : PW'($urandom_range(0, 3));
    end
    rst_n = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
